myo_quad_gen: RTL
=================

// Module: myo_quad_gen
// PURPOSE
//  Quadrature encoder emulator: transmit side of the RS422 quad link. Avalon-MM slave sets a target count.
//  Block steps its internal count toward the target at a programmable edge rate and drives differential A/B.
//  Used for hardware-in-the-loop test of the quad decoder and for motor-board bring-up without encoders.
// PARAMETERS
//  CLOCK_FREQ_HZ  50_000_000  system clock frequency; informational, for period computation in software
//  MIN_PERIOD     4           minimum clocks between quadrature edges; smaller programmed periods clamp to it
//  INDEX_PERIOD   2048        counts per index pulse (used only with MYO_QUAD_GEN_INDEX_EN)
// PORTS
//  clk        in   1   system clock
//  reset_n    in   1   asynchronous reset, active low
//  address    in   4   Avalon word address
//  write      in   1   Avalon write strobe
//  writedata  in   32  Avalon write data, signed
//  read       in   1   Avalon read strobe
//  readdata   out  32  Avalon read data
//  waitrequest out 1   Avalon wait; high on the first cycle of each read
//  quad_Apos  out  1   channel A positive leg (= ~A)
//  quad_Aneg  out  1   channel A negative leg (= A)
//  quad_Bpos  out  1   channel B positive leg (= ~B)
//  quad_Bneg  out  1   channel B negative leg (= B)
// BEHAVIOUR
//  Clock and reset: one clock domain; reset is asynchronous and active-low.
//  Reset state (async on reset_n=0): target=0, count=0, period=MIN_PERIOD, enable=0, phase=00.
//   All outputs are registered. Reset values: A=B=0, so Aneg=Bneg=0, Apos=Bpos=1. readdata=0, waitrequest=1.
//  Register map:
//   0 target (RW, s32)
//   1 period in clks (RW, u32)
//   2 count (R; W preloads count without emitting an edge)
//   3 ctrl (RW; bit0 enable)
//   4 status (R; bit0 busy = count!=target, bit1 dir)
//   other addresses read 32'hDEADBEEF; writes to them are ignored.
//  Read: cycle 1 waitrequest=1. Cycle 2: readdata is valid and waitrequest=0. Writes complete in 1 cycle, no wait.
//  Step FSM states: IDLE, WAIT, STEP.
//   IDLE: if enable and count!=target, load the timer with max(period,MIN_PERIOD) and go to WAIT.
//   WAIT: decrement the timer; at 0 go to STEP.
//   STEP: diff=target-count (s32, wraps modulo 2^32); dir=up if diff>0, else down.
//    count+=1 or -=1 (wraps at 32 bits); phase advances one Gray step; then go to IDLE.
//    IDLE re-evaluates the same cycle, so the edge spacing is exactly the programmed period.
//  Gray sequence (A,B), counting up: 00 -> 10 -> 11 -> 01 -> 00. Down is the reverse. Exactly one output bit changes per STEP.
//  Boundaries:
//   Target rewritten mid-WAIT: the timer is not restarted; the new direction applies at STEP.
//   Target equal to count: no edges are emitted.
//   enable cleared: the FSM returns to IDLE at once and the outputs hold their level.
//   Period write: takes effect at the next timer load.
//   Count preload together with a STEP in the same cycle: the preload wins; the phase still advances.
//   reset_n asserted mid-move: immediate return to the reset state; a pending edge is lost.
// CONFIGURATION
//  MYO_QUAD_GEN_INDEX_EN defined:
//   Adds outputs quad_Ipos/quad_Ineg. Index I=1 for the single STEP-phase state where count mod INDEX_PERIOD==0 and phase==00.
//   Adds register 5: index count (R, u32), incremented at each I rising edge.
//  Not defined: no index ports; address 5 reads DEADBEEF.
// STRUCTURE
//  Package myo_quad_pkg: register address localparams, FSM state enum, Gray next/prev table, DEADBEEF constant.
//  Sub-module quad_step_timer: loadable down-counter with clamp to MIN_PERIOD and a done pulse.
//  Top holds the Avalon registers, the step FSM and the output drivers.
// TESTING
//  1. Reset, read all regs -> target=0, count=0, status=0. Aneg=Bneg=0, Apos=Bpos=1, addr 7 = DEADBEEF.
//  2. period=10, target=8, enable=1 -> 8 edges exactly 10 clks apart, Gray up sequence, count=8, busy=0.
//  3. target=-3 from count 0 -> down sequence 00,01,11,10. count reads 0xFFFFFFFD.
//  4. Loop the outputs into the quad decoder. target=+1000 then -500 -> decoder pos_0 tracks the count each edge.
//  5. period=1 -> edge spacing=MIN_PERIOD (4). Clear enable mid-move -> outputs freeze, count stable.
//  6. Preload count=0x7FFFFFFF, target=0x80000001 -> 2 up steps that wrap. Pulse reset_n mid-WAIT -> async reset values.

Source files
------------

// File: rtl/myo_quad_gen_pkg.sv
// Shared definitions for the quadrature encoder emulator.
//   - Avalon register word addresses
//   - step FSM state encoding
//   - Gray step tables for the (A,B) phase pair
//   - read value returned for unmapped addresses
package myo_quad_pkg;

  localparam logic [3:0] ADDR_TARGET = 4'd0;
  localparam logic [3:0] ADDR_PERIOD = 4'd1;
  localparam logic [3:0] ADDR_COUNT  = 4'd2;
  localparam logic [3:0] ADDR_CTRL   = 4'd3;
  localparam logic [3:0] ADDR_STATUS = 4'd4;
  localparam logic [3:0] ADDR_INDEX  = 4'd5;

  localparam logic [31:0] RD_UNMAPPED = 32'hDEAD_BEEF;

  localparam int unsigned MIN_PERIOD_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_STEP = 2'd2
  } step_state_e;

  // Phase is {A,B}. Up: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] gray_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] gray_prev(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/myo_quad_gen_timer.sv
// quad_step_timer: loadable down-counter that times the gap between edges.
//   clk, reset_n  clock / async active-low reset
//   load_i        load the counter from period_i (clamped to MIN_PERIOD)
//   dec_i         decrement enable
//   period_i      programmed period in clocks
//   done_o        pulse on the decrement that reaches zero
// The counter is loaded with period-1 so that, counting the load cycle, the
// distance between two loads that each end in done is exactly the period.
// MIN_PERIOD must be at least 2.
module quad_step_timer
  import myo_quad_pkg::*;
#(
  parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic        dec_i,
  input  logic [31:0] period_i,
  output logic        done_o
);

  logic [31:0] cnt_q;
  logic [31:0] load_val;

  assign load_val = (period_i < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) - 32'd1
                                                 : period_i - 32'd1;
  assign done_o   = dec_i && (cnt_q == 32'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 32'd0;
    end else if (load_i) begin
      cnt_q <= load_val;
    end else if (dec_i && (cnt_q != 32'd0)) begin
      cnt_q <= cnt_q - 32'd1;
    end
  end

endmodule

// File: rtl/myo_quad_gen.sv
// myo_quad_gen: quadrature encoder emulator, transmit side of the RS422 link.
// An Avalon-MM slave sets a target count; the block steps its count toward it
// one Gray edge per programmed period and drives differential A/B legs.
//   clk, reset_n            clock / async active-low reset
//   address, write,         Avalon-MM slave: word address, write strobe,
//   writedata, read,        data, read strobe, read data and wait
//   readdata, waitrequest   (reads take two cycles, writes one)
//   quad_Apos/Aneg          channel A legs (Apos = ~A, Aneg = A)
//   quad_Bpos/Bneg          channel B legs (Bpos = ~B, Bneg = B)
//   quad_Ipos/Ineg          index legs, only with MYO_QUAD_GEN_INDEX_EN
// Optional feature macro: MYO_QUAD_GEN_INDEX_EN (index output + register 5).
//
// state | meaning
// IDLE  | at target or disabled; loads the timer when a move is pending
// WAIT  | timer running toward the next edge
// STEP  | emit one Gray edge, move count by one, re-arm if still busy
module myo_quad_gen
  import myo_quad_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_HZ = 50_000_000,
  parameter int unsigned MIN_PERIOD    = MIN_PERIOD_DEF,
  parameter int unsigned INDEX_PERIOD  = 2048
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        quad_Apos,
  output logic        quad_Aneg,
  output logic        quad_Bpos,
  output logic        quad_Bneg
`ifdef MYO_QUAD_GEN_INDEX_EN
  ,
  output logic        quad_Ipos,
  output logic        quad_Ineg
`endif
);

  step_state_e state_q, state_d;
  logic [31:0] target_q, period_q, count_q, count_d, diff;
  logic [31:0] readdata_q, rd_data;
  logic [1:0]  phase_q, phase_d;
  logic [3:0]  legs_q;  // {Apos, Aneg, Bpos, Bneg}
  logic        enable_q, waitreq_q;
  logic        dir_up, step_en, timer_load, timer_dec, timer_done;
  logic        wr_target, wr_period, wr_count, wr_ctrl;
  logic        unused_cfg;

  assign unused_cfg = ^{CLOCK_FREQ_HZ, INDEX_PERIOD};

  assign wr_target = write && (address == ADDR_TARGET);
  assign wr_period = write && (address == ADDR_PERIOD);
  assign wr_count  = write && (address == ADDR_COUNT);
  assign wr_ctrl   = write && (address == ADDR_CTRL);

  // Signed modulo-2^32 distance decides direction, so wrapped targets step
  // the short way round.
  assign diff    = target_q - count_q;
  assign dir_up  = $signed(diff) > 0;
  assign step_en = (state_q == ST_STEP) && enable_q;

  quad_step_timer #(.MIN_PERIOD(MIN_PERIOD)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (timer_load),
    .dec_i    (timer_dec),
    .period_i (period_q),
    .done_o   (timer_done)
  );

  // A count preload in the same cycle as a step overrides the step's count
  // update, but the phase still advances.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (step_en) begin
      count_d = dir_up ? count_q + 32'd1 : count_q - 32'd1;
      phase_d = dir_up ? gray_next(phase_q) : gray_prev(phase_q);
    end
    if (wr_count) count_d = writedata;
  end

  // STEP re-runs the IDLE decision itself so the next timer load happens in
  // the step cycle; that keeps edge spacing equal to the period.
  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_q && (count_q != target_q)) begin
          timer_load = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_dec = enable_q;
        if (!enable_q)      state_d = ST_IDLE;
        else if (timer_done) state_d = ST_STEP;
      end
      ST_STEP: begin
        state_d = ST_IDLE;
        if (enable_q && (count_d != target_q)) begin
          timer_load = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef MYO_QUAD_GEN_INDEX_EN
  logic        idx_d, idx_q;
  logic [1:0]  idx_legs_q;  // {Ipos, Ineg}
  logic [31:0] index_cnt_q;

  assign idx_d = ((count_d % INDEX_PERIOD) == 32'd0) && (phase_d == 2'b00);

  // Reset state already sits on the index position, so I resets high and the
  // first cycle after reset does not count as a rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q       <= 1'b1;
      idx_legs_q  <= 2'b01;
      index_cnt_q <= 32'd0;
    end else begin
      idx_q      <= idx_d;
      idx_legs_q <= {~idx_d, idx_d};
      if (idx_d && !idx_q) index_cnt_q <= index_cnt_q + 32'd1;
    end
  end

  assign quad_Ipos = idx_legs_q[1];
  assign quad_Ineg = idx_legs_q[0];
`endif

  always_comb begin
    case (address)
      ADDR_TARGET: rd_data = target_q;
      ADDR_PERIOD: rd_data = period_q;
      ADDR_COUNT:  rd_data = count_q;
      ADDR_CTRL:   rd_data = {31'd0, enable_q};
      ADDR_STATUS: rd_data = {30'd0, dir_up, (count_q != target_q)};
`ifdef MYO_QUAD_GEN_INDEX_EN
      ADDR_INDEX:  rd_data = index_cnt_q;
`endif
      default:     rd_data = RD_UNMAPPED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      target_q   <= 32'd0;
      period_q   <= 32'(MIN_PERIOD);
      count_q    <= 32'd0;
      enable_q   <= 1'b0;
      phase_q    <= 2'b00;
      legs_q     <= 4'b1010;
      readdata_q <= 32'd0;
      waitreq_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      phase_q <= phase_d;
      legs_q  <= {~phase_d[1], phase_d[1], ~phase_d[0], phase_d[0]};
      if (wr_target) target_q <= writedata;
      if (wr_period) period_q <= writedata;
      if (wr_ctrl)   enable_q <= writedata[0];
      // waitrequest idles high; a read drops it for one cycle with data.
      if (read && waitreq_q) begin
        waitreq_q  <= 1'b0;
        readdata_q <= rd_data;
      end else begin
        waitreq_q  <= 1'b1;
      end
    end
  end

  assign readdata    = readdata_q;
  assign waitrequest = waitreq_q;
  assign quad_Apos   = legs_q[3];
  assign quad_Aneg   = legs_q[2];
  assign quad_Bpos   = legs_q[1];
  assign quad_Bneg   = legs_q[0];

endmodule
